// File: rtl/telemetry_frame_tx.sv
// rtl/telemetry_frame_tx.sv - snapshot X/Y/Z coordinates and send one framed 8N1 packet
module telemetry_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_valid,
  output logic       send_ready,
  input  logic [7:0] coord_x,
  input  logic [7:0] coord_y,
  input  logic [7:0] coord_z,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frame_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BYTE_LAST = 3'd4;

  logic [1:0]  state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  z_q, z_d;
  logic [7:0]  chk_q, chk_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic [7:0]  frame_count_q, frame_count_d;

  logic [7:0]  cur_byte;
  logic        bit_end;

  // Select the byte of the frame currently on the line from the snapshot
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx_q)
      3'd1:    cur_byte = x_q;
      3'd2:    cur_byte = y_q;
      3'd3:    cur_byte = z_q;
      3'd4:    cur_byte = chk_q;
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  assign bit_end = (cyc_q == BIT_LAST);

  // Frame sequencer: next tx level is computed here so the line comes straight off a flop
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    bit_idx_d     = bit_idx_q;
    byte_idx_d    = byte_idx_q;
    x_d           = x_q;
    y_d           = y_q;
    z_d           = z_q;
    chk_d         = chk_q;
    tx_d          = tx_q;
    ready_d       = ready_q;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (send_valid && ready_q) begin
          x_d        = coord_x;
          y_d        = coord_y;
          z_d        = coord_z;
          chk_d      = coord_x + coord_y + coord_z;
          ready_d    = 1'b0;
          state_d    = S_START;
          tx_d       = 1'b0;
          cyc_d      = 16'd0;
          bit_idx_d  = 3'd0;
          byte_idx_d = 3'd0;
        end
      end

      S_START: begin
        if (bit_end) begin
          cyc_d     = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          tx_d      = cur_byte[0];
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cyc_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          cyc_d = 16'd0;
          if (byte_idx_q < BYTE_LAST) begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = S_START;
            tx_d       = 1'b0;
          end else begin
            byte_idx_d    = 3'd0;
            state_d       = S_IDLE;
            ready_d       = 1'b1;
            tx_d          = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        cyc_d   = 16'd0;
      end
    endcase
  end

  // State registers; reset forces the line high at once and abandons any frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cyc_q         <= 16'd0;
      bit_idx_q     <= 3'd0;
      byte_idx_q    <= 3'd0;
      x_q           <= 8'd0;
      y_q           <= 8'd0;
      z_q           <= 8'd0;
      chk_q         <= 8'd0;
      tx_q          <= 1'b1;
      ready_q       <= 1'b1;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      bit_idx_q     <= bit_idx_d;
      byte_idx_q    <= byte_idx_d;
      x_q           <= x_d;
      y_q           <= y_d;
      z_q           <= z_d;
      chk_q         <= chk_d;
      tx_q          <= tx_d;
      ready_q       <= ready_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign tx          = tx_q;
  assign send_ready  = ready_q;
  assign busy        = !ready_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_telemetry_frame_tx.sv
// tb/tb_telemetry_frame_tx.sv - randomized self-checking bench for telemetry_frame_tx
module tb_telemetry_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cx, cy, cz;
  logic       sv  [3];
  logic       txw [3];
  logic       rdy [3];
  logic       bsy [3];
  logic [7:0] fcw [3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_fc [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  telemetry_frame_tx #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .send_valid(sv[0]), .send_ready(rdy[0]),
    .coord_x(cx), .coord_y(cy), .coord_z(cz),
    .tx(txw[0]), .busy(bsy[0]), .frame_count(fcw[0])
  );

  telemetry_frame_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .send_valid(sv[1]), .send_ready(rdy[1]),
    .coord_x(cx), .coord_y(cy), .coord_z(cz),
    .tx(txw[1]), .busy(bsy[1]), .frame_count(fcw[1])
  );

  telemetry_frame_tx #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .send_valid(sv[2]), .send_ready(rdy[2]),
    .coord_x(cx), .coord_y(cy), .coord_z(cz),
    .tx(txw[2]), .busy(bsy[2]), .frame_count(fcw[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bytes packed LSB-first: byte 0 is sync, byte 4 is checksum
  function automatic logic [39:0] mk_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    int s;
    s = (int'(x) + int'(y) + int'(z)) % 256;
    return {8'(s), z, y, x, 8'hA5};
  endfunction

  // Line level for serial bit p of the frame (10 bits per byte: start, 8 data LSB first, stop)
  function automatic logic exp_bit(input logic [39:0] f, input int p);
    int k;
    int pos;
    k   = p / 10;
    pos = p % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return f[8*k + pos - 1];
  endfunction

  // Wait for a start bit on DUT d, then compare the line every cycle and decode each byte mid-bit
  task automatic capture(input int d, input int cpb, input logic [39:0] ef, input bit hold, output int t0);
    int waited;
    int errs;
    int p;
    int pos;
    logic [7:0] rb;
    waited = 0;
    errs   = 0;
    rb     = 8'h00;
    t0     = -1;
    @(negedge clk);
    while (txw[d] !== 1'b0 && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    if (txw[d] !== 1'b0) begin
      check("start_seen", 32'd0, 32'd1);
      return;
    end
    t0 = cyc;
    if (!hold) sv[d] = 1'b0;
    for (int j = 0; j < 50*cpb; j++) begin
      if (j > 0) @(negedge clk);
      if (txw[d] !== exp_bit(ef, j / cpb)) errs++;
      if (rdy[d] !== 1'b0 || bsy[d] !== 1'b1) errs++;
      if (j % cpb == cpb / 2) begin
        p   = j / cpb;
        pos = p % 10;
        if (pos >= 1 && pos <= 8) rb[pos-1] = txw[d];
        if (pos == 9) check("rx_byte", rb, ef[8*(p/10) +: 8]);
      end
    end
    @(negedge clk);
    exp_fc[d] = (exp_fc[d] + 1) % 256;
    check("wave", errs, 0);
    check("ready_back", rdy[d], 1);
    check("busy_clr", bsy[d], 0);
    check("frame_count", fcw[d], exp_fc[d]);
  endtask

  initial begin
    int t, tprev, bad;
    for (int i = 0; i < 3; i++) begin
      sv[i] = 1'b0;
      exp_fc[i] = 0;
    end
    cx = 8'h00; cy = 8'h00; cz = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_tx", txw[i], 1);
      check("rst_ready", rdy[i], 1);
      check("rst_busy", bsy[i], 0);
      check("rst_fc", fcw[i], 0);
    end

    // Basic frame
    cx = 8'h12; cy = 8'h34; cz = 8'h56; sv[0] = 1'b1;
    capture(0, 16, mk_frame(8'h12, 8'h34, 8'h56), 1'b0, t);
    check("chk_9c", mk_frame(8'h12, 8'h34, 8'h56) >> 32, 32'h9C);

    // Checksum wrap cases
    cx = 8'hFF; cy = 8'hFF; cz = 8'h02; sv[0] = 1'b1;
    capture(0, 16, mk_frame(8'hFF, 8'hFF, 8'h02), 1'b0, t);
    cx = 8'h80; cy = 8'h80; cz = 8'h00; sv[0] = 1'b1;
    capture(0, 16, mk_frame(8'h80, 8'h80, 8'h00), 1'b0, t);

    // Random coordinates
    for (int i = 0; i < 4; i++) begin
      cx = 8'($urandom); cy = 8'($urandom); cz = 8'($urandom); sv[0] = 1'b1;
      capture(0, 16, mk_frame(cx, cy, cz), 1'b0, t);
    end

    // Inputs churn and send_valid pulses mid-frame
    cx = 8'h01; cy = 8'h02; cz = 8'h03; sv[0] = 1'b1;
    fork
      capture(0, 16, {8'h06, 8'h03, 8'h02, 8'h01, 8'hA5}, 1'b0, t);
      begin
        repeat (5) @(negedge clk);
        repeat (700) begin
          @(negedge clk);
          cx = 8'($urandom); cy = 8'($urandom); cz = 8'($urandom);
          sv[0] = 1'($urandom_range(0, 1));
        end
        sv[0] = 1'b0;
      end
    join
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txw[0] !== 1'b1 || rdy[0] !== 1'b1) bad++;
    end
    check("no_extra_frame", bad, 0);
    check("fc_after_churn", fcw[0], exp_fc[0]);

    // Reset in the middle of a frame
    cx = 8'h12; cy = 8'h34; cz = 8'h56; sv[0] = 1'b1;
    bad = 0;
    @(negedge clk);
    while (txw[0] !== 1'b0 && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    sv[0] = 1'b0;
    repeat (299) @(negedge clk);
    check("pre_rst_tx_low", txw[0], 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx_async", txw[0], 1);
    check("rst_ready_async", rdy[0], 1);
    check("rst_fc_zero", fcw[0], 0);
    for (int i = 0; i < 3; i++) exp_fc[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cx = 8'($urandom); cy = 8'($urandom); cz = 8'($urandom); sv[0] = 1'b1;
    capture(0, 16, mk_frame(cx, cy, cz), 1'b0, t);

    // Back-to-back, CLKS_PER_BIT=4
    cx = 8'($urandom); cy = 8'($urandom); cz = 8'($urandom); sv[1] = 1'b1;
    tprev = 0;
    for (int f = 0; f < 3; f++) begin
      capture(1, 4, mk_frame(cx, cy, cz), 1'b1, t);
      if (f > 0) check("b2b_gap4", t - tprev, 201);
      tprev = t;
      if (f < 2) begin
        cx = 8'($urandom); cy = 8'($urandom); cz = 8'($urandom);
      end else begin
        sv[1] = 1'b0;
      end
    end
    check("fc_three", fcw[1], 3);

    // 257 back-to-back frames, CLKS_PER_BIT=2, counter wrap
    cx = 8'($urandom); cy = 8'($urandom); cz = 8'($urandom); sv[2] = 1'b1;
    for (int f = 0; f < 257; f++) begin
      capture(2, 2, mk_frame(cx, cy, cz), 1'b1, t);
      if (f > 0 && (f % 32 == 0 || f > 250)) check("b2b_gap2", t - tprev, 101);
      tprev = t;
      if (f == 255) check("fc_wrap_zero", fcw[2], 0);
      if (f < 256) begin
        cx = 8'($urandom); cy = 8'($urandom); cz = 8'($urandom);
      end else begin
        sv[2] = 1'b0;
      end
    end
    check("fc_wrap_one", fcw[2], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/telemetry_frame_tx.md
Name: telemetry_frame_tx

Overview:
- Transmit side of the telemetry coordinate path.
- On request, snapshots the current 8-bit X/Y/Z coordinate registers.
- Serialises one framed packet (sync byte, X, Y, Z, checksum) on a single UART-style 8N1 line toward the ground link.
- Counts completed frames for link-health monitoring.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- send_valid  input  1  request to send one frame.
- send_ready  output  1  block can accept a request this cycle.
- coord_x  input  8  X coordinate; sampled only at acceptance.
- coord_y  input  8  Y coordinate; sampled only at acceptance.
- coord_z  input  8  Z coordinate; sampled only at acceptance.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress; always equals !send_ready.
- frame_count  output  8  completed-frame counter; wraps.

Behaviour:
- Reset (async assert, sync release): tx=1, send_ready=1, busy=0, frame_count=0, state=IDLE. All snapshot, bit, byte and cycle counters are cleared.
- Handshake: a request is accepted on a rising edge where send_valid && send_ready.
  - On that same edge: coord_x/y/z are registered, checksum = (X+Y+Z) mod 256 is registered, send_ready<=0, state<=START, tx<=0.
  - send_valid while busy is ignored. It is not queued.
- Frame: 5 bytes in order SYNC_BYTE, X, Y, Z, CHK.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Each bit is held exactly CLKS_PER_BIT cycles, timed by a cycle counter counting 0..CLKS_PER_BIT-1.
- States:
  - IDLE: tx=1.
  - START: tx=0. After CLKS_PER_BIT cycles, go to DATA with bit index 0.
  - DATA: tx=current byte[bit index]. After each bit period, bit index increments. After bit 7, go to STOP.
  - STOP: tx=1. After the bit period:
    - if byte index < 4: byte index increments, go to START.
    - else go to IDLE. On that edge send_ready<=1 and frame_count increments.
- Latency: accept edge to send_ready reassertion is exactly 50*CLKS_PER_BIT cycles.
- Back-to-back requests: if send_valid is held high, the next accept occurs one cycle after send_ready rises. The last stop bit is therefore extended by exactly one cycle, and consecutive start-bit falling edges are 50*CLKS_PER_BIT+1 cycles apart.
- Coordinate inputs changing mid-frame have no effect on the frame being sent.
- frame_count wraps from 255 to 0. It increments only on completed frames.
- Reset asserted mid-frame: tx goes to 1 immediately (asynchronously) and the frame is abandoned. No frame_count increment. After release, the block is in IDLE with send_ready=1.
- Checksum arithmetic is 8-bit and discards carries. The sync byte is excluded from the checksum.
- tx is driven directly from a flop (glitch-free, no combinational path from inputs).

Test Plan:
1. CLKS_PER_BIT=16, X=0x12, Y=0x34, Z=0x56, single pulse of send_valid.
   - tx decodes as A5, 12, 34, 56, 9C.
   - Start bit falls on the accept edge. Each bit lasts 16 cycles.
   - send_ready returns 800 cycles after accept. frame_count=1.
2. Checksum wrap: X=0xFF, Y=0xFF, Z=0x02.
   - Checksum byte = 0x00.
   - Second case X=0x80, Y=0x80, Z=0x00: checksum byte = 0x00.
3. Change X/Y/Z every cycle during a frame accepted with 0x01/0x02/0x03.
   - Frame is A5, 01, 02, 03, 06.
   - send_valid pulses mid-frame produce no extra frame.
4. Hold send_valid high for 3 frames at CLKS_PER_BIT=4.
   - Start-bit falling edges are exactly 201 cycles apart.
   - frame_count=3 after the third frame.
5. Assert rst_n low at cycle 300 of a frame (CLKS_PER_BIT=16).
   - tx=1 immediately, with no clock edge required.
   - frame_count unchanged at 0.
   - After release, a new request sends a complete, correct frame.
6. CLKS_PER_BIT=2, 257 back-to-back frames.
   - frame_count goes 255 -> 0 -> 1.
   - The line shows no framing errors throughout.
